// File: rtl/alu_arb_pkg.sv
// Shared widths, opcodes and FSM state encoding for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned W   = 4;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_NOT = 3'b010;
  localparam logic [OPW-1:0] OP_AND = 3'b011;
  localparam logic [OPW-1:0] OP_OR  = 3'b100;
  localparam logic [OPW-1:0] OP_XOR = 3'b101;
  localparam logic [OPW-1:0] OP_LT  = 3'b110;
  localparam logic [OPW-1:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit two's-complement ALU with zero/carry/overflow flags.
module alu4_core
  import alu_arb_pkg::*;
(
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result,
  output logic           zero,
  output logic           carry,
  output logic           ovf
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // a + ~b + 1 leaves bit W set when there is no borrow
    diff   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
        ovf    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        result = diff[W-1:0];
        carry  = diff[W];
        ovf    = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LT:   result = W'($signed(a) < $signed(b));
      OP_EQ:   result = W'(a == b);
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arb_seq.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional per-requester grant and conflict counters under ALU_ARB_STATS_EN.
module alu_arb_seq
  import alu_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_zero,
  output logic           rsp_carry,
  output logic           rsp_ovf,
  output logic           busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]     stat_grant0,
  output logic [7:0]     stat_grant1,
  output logic [7:0]     stat_conflict
`endif
);

  state_t         state;
  logic           last_grant;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           id_q;

  logic [W-1:0]   alu_result;
  logic           alu_zero;
  logic           alu_carry;
  logic           alu_ovf;

  // Winner is the sole valid requester, or the one not granted last on a tie
  assign req0_ready = (state == ST_IDLE) && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = (state == ST_IDLE) && req1_valid && (!req0_valid || !last_grant);

  alu4_core u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0_ready || req1_ready) begin
            op_q       <= req1_ready ? req1_op : req0_op;
            a_q        <= req1_ready ? req1_a  : req0_a;
            b_q        <= req1_ready ? req1_b  : req0_b;
            id_q       <= req1_ready;
            last_grant <= req1_ready;
            state      <= ST_EXEC;
            busy       <= 1'b1;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_carry  <= alu_carry;
          rsp_ovf    <= alu_ovf;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating usage counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (req0_ready && stat_grant0 != 8'hFF)
        stat_grant0 <= stat_grant0 + 8'd1;
      if (req1_ready && stat_grant1 != 8'hFF)
        stat_grant1 <= stat_grant1 + 8'd1;
      if (state == ST_IDLE && req0_valid && req1_valid && stat_conflict != 8'hFF)
        stat_conflict <= stat_conflict + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arb_seq.sv
// Self-checking bench for alu_arb_seq; counter checks compile in with ALU_ARB_STATS_EN.
module tb_alu_arb_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_zero, rsp_carry, rsp_ovf, busy;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit exp_last = 1'b1;

  alu_arb_seq dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_ovf(rsp_ovf), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: {result[3:0], zero, carry, ovf} from integer arithmetic
  function automatic logic [6:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      3'd0: begin r = (ua + ub) % 16; c = (ua + ub) > 15; s = sa + sb; v = (s > 7) || (s < -8); end
      3'd1: begin r = (ua - ub + 16) % 16; c = ua >= ub; s = sa - sb; v = (s > 7) || (s < -8); end
      3'd2: r = 15 - ua;
      3'd3: r = int'(a & b);
      3'd4: r = int'(a | b);
      3'd5: r = int'(a ^ b);
      3'd6: r = (sa < sb) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    return {4'(r), (r == 0), c, v};
  endfunction

  task automatic set_req(input bit id, input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  // Offers one command at a negedge, waits for accept and then for rsp_valid
  task automatic do_cmd(input bit id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic [6:0] got, output logic rid, output bit ok);
    int acc;
    ok = 0; lat = -1; got = '0; rid = 1'b0; acc = 0;
    set_req(id, 1'b1, op, a, b);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin set_req(id, 1'b0, op, a, b); return; end
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    // Accepted command must be immune to later requester activity
    set_req(id, 1'b0, 3'($urandom), 4'($urandom), 4'($urandom));
    exp_last = id;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    lat = cyc - acc;
    got = {rsp_result, rsp_zero, rsp_carry, rsp_ovf};
    rid = rsp_id;
  endtask

  task automatic test_reset;
    rst = 1'b1; rsp_ready = 1'b1;
    set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
    set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_last = 1'b1;
    n_chk++;
    if ({rsp_valid, busy, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b busy=%b id=%b res=%h z=%b c=%b o=%b want all 0",
               rsp_valid, busy, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf);
    end
`ifdef ALU_ARB_STATS_EN
    n_chk++;
    if ({stat_grant0, stat_grant1, stat_conflict} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", stat_grant0, stat_grant1, stat_conflict);
    end
`endif
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_grant got ready1/0=%b%b want 01", req1_ready, req0_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_add;
    int lat; logic [6:0] got; logic rid; bit ok;
    do_cmd(0, 3'b000, 4'b0111, 4'b0001, lat, got, rid, ok);
    n_chk++;
    if (!ok || lat != 2) begin n_fail++; $display("FAIL add_latency got %0d ok=%0d want 2", lat, ok); end
    n_chk++;
    if ({rid, got} !== {1'b0, 4'b1000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL add_result got id=%b res/z/c/o=%b want id=0 1000001", rid, got);
    end
    @(negedge clk);
  endtask

  task automatic test_sub_neg;
    int lat; logic [6:0] got; logic rid; bit ok;
    do_cmd(1, 3'b001, 4'b1110, 4'b0001, lat, got, rid, ok);
    n_chk++;
    if (!ok || {rid, got} !== {1'b1, 4'b1101, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sub_neg got ok=%0d id=%b res/z/c/o=%b want id=1 1101010", ok, rid, got);
    end
    @(negedge clk);
  endtask

  task automatic test_compare;
    int lat; logic [6:0] got; logic rid; bit ok;
    logic [2:0] ops [3] = '{3'b110, 3'b111, 3'b011};
    logic [3:0] as  [3] = '{4'b1111, 4'b0101, 4'b1010};
    logic [3:0] bs  [3] = '{4'b0001, 4'b0101, 4'b0101};
    logic [6:0] wants [3] = '{7'b0001_000, 7'b0001_000, 7'b0000_100};
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'(i & 1), ops[i], as[i], bs[i], lat, got, rid, ok);
      n_chk++;
      if (!ok || got !== wants[i]) begin
        n_fail++; $display("FAIL compare_%0d got ok=%0d res/z/c/o=%b want %b", i, ok, got, wants[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int lat; logic [6:0] got, exp; logic rid; bit ok, id;
    logic [2:0] op; logic [3:0] a, b;
    for (int i = 0; i < 40; i++) begin
      id = 1'($urandom); op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
      exp = model(op, a, b);
      do_cmd(id, op, a, b, lat, got, rid, ok);
      n_chk++;
      if (!ok || lat != 2 || rid !== id || got !== exp) begin
        n_fail++;
        $display("FAIL random_%0d op=%b a=%h b=%h got ok=%0d lat=%0d id=%b %b want lat=2 id=%b %b",
                 i, op, a, b, ok, lat, rid, got, id, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_conflict;
    logic [2:0] op [2]; logic [3:0] a [2]; logic [3:0] b [2];
    logic [6:0] exp; bit want, found;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] c0, g0, g1;
    c0 = stat_conflict; g0 = stat_grant0; g1 = stat_grant1;
`endif
    rsp_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      op[r] = 3'($urandom); a[r] = 4'($urandom); b[r] = 4'($urandom);
      set_req(1'(r), 1'b1, op[r], a[r], b[r]);
    end
    for (int g = 0; g < 4; g++) begin
      want = !exp_last;
      found = 0;
      for (int k = 0; k < 10; k++) begin
        #1;
        if (req0_ready || req1_ready) begin found = 1; break; end
        @(negedge clk);
      end
      n_chk++;
      if (!found || {req1_ready, req0_ready} !== (want ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL conflict_grant_%0d got ready1/0=%b%b want winner %0d", g, req1_ready, req0_ready, want);
      end
      exp = model(op[want], a[want], b[want]);
      exp_last = want;
      @(posedge clk);
      @(negedge clk);
      op[want] = 3'($urandom); a[want] = 4'($urandom); b[want] = 4'($urandom);
      set_req(want, 1'b1, op[want], a[want], b[want]);
      found = 0;
      for (int k = 0; k < 10; k++) begin
        #1;
        if (req0_ready || req1_ready) break;
        if (rsp_valid) begin found = 1; break; end
        @(negedge clk);
      end
      n_chk++;
      if (!found || rsp_id !== want || {rsp_result, rsp_zero, rsp_carry, rsp_ovf} !== exp) begin
        n_fail++;
        $display("FAIL conflict_rsp_%0d got ok=%0d id=%b %b want id=%b %b", g, found, rsp_id,
                 {rsp_result, rsp_zero, rsp_carry, rsp_ovf}, want, exp);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_ARB_STATS_EN
    n_chk++;
    if (8'(stat_conflict - c0) !== 8'd4 || 8'(stat_grant0 - g0) !== 8'd2 || 8'(stat_grant1 - g1) !== 8'd2) begin
      n_fail++;
      $display("FAIL conflict_stats got dconf=%0d dg0=%0d dg1=%0d want 4/2/2",
               8'(stat_conflict - c0), 8'(stat_grant0 - g0), 8'(stat_grant1 - g1));
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat; logic [6:0] got, exp; logic rid; bit ok, bad;
    rsp_ready = 1'b0;
    exp = model(3'b101, 4'b1100, 4'b0110);
    do_cmd(0, 3'b101, 4'b1100, 4'b0110, lat, got, rid, ok);
    n_chk++;
    if (!ok || got !== exp || rid !== 1'b0) begin
      n_fail++; $display("FAIL bp_rsp got ok=%0d id=%b %b want id=0 %b", ok, rid, got, exp);
    end
    set_req(0, 1'b1, 3'($urandom), 4'($urandom), 4'($urandom));
    set_req(1, 1'b1, 3'($urandom), 4'($urandom), 4'($urandom));
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!rsp_valid || !busy || req0_ready || req1_ready || rsp_id !== 1'b0 ||
          {rsp_result, rsp_zero, rsp_carry, rsp_ovf} !== exp) bad = 1;
      @(negedge clk);
    end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL bp_hold got v=%b busy=%b rdy=%b%b %b want 1 1 00 %b",
                         rsp_valid, busy, req1_ready, req0_ready, {rsp_result, rsp_zero, rsp_carry, rsp_ovf}, exp);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got busy=%b v=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    set_req(0, 1'b1, 3'b000, 4'd3, 4'd4);
    #1;
    n_chk++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_accept got %b want 1", req0_ready); end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_exec_busy got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_last = 1'b1;
    n_chk++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle got busy=%b v=%b want 0 0", busy, rsp_valid);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen = 1;
      @(negedge clk);
    end
    n_chk++;
    if (seen) begin n_fail++; $display("FAIL midrst_no_rsp got rsp_valid=1 want 0"); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL midrst_grant got ready1/0=%b%b want 01", req1_ready, req0_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset;
    test_single_add;
    test_sub_neg;
    test_compare;
    test_conflict;
    test_backpressure;
    test_random;
    test_reset_mid;
    test_conflict;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
